// File: rtl/readout_capture.sv
// Readout capture: buffers a programmed burst of ADC samples, sums them,
// then streams the buffered samples out over a valid/ready port.
module readout_capture #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic                     start_collect,
  input  logic [ADDR_W:0]          num_samples,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     adc_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [DATA_W+ADDR_W:0]   sum,
  output logic                     sum_valid,
  output logic                     busy,
  output logic                     missed_trigger
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam int SUM_W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_ptr;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  acc_next;
  logic [SUM_W-1:0]  sample_ext;
  logic [ADDR_W:0]   n_clamped;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] mem_q;
  logic              pv;
  logic              pl;

  logic cap;
  logic last_wr;
  logic take;
  logic load;
  logic rd_en;

  assign busy       = (state != S_IDLE);
  assign cap        = (state == S_CAPTURE) && adc_valid;
  assign last_wr    = (wr_cnt == count - ONE);
  assign sample_ext = {{(ADDR_W+1){adc_data[DATA_W-1]}}, adc_data};
  assign acc_next   = acc + sample_ext;
  assign n_clamped  = (num_samples == '0 || num_samples > FULL)
                      ? FULL : num_samples;

  // Output register takes the prefetched word when empty or draining;
  // a new read is issued whenever the prefetch slot will be free.
  assign take  = out_valid && out_ready;
  assign load  = pv && (!out_valid || out_ready);
  assign rd_en = (state == S_DRAIN) && (rd_ptr != count)
                 && (!pv || load);

  // Control FSM, accumulator, sum and sticky miss flag
  always_ff @(posedge clk100) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      wr_cnt         <= '0;
      acc            <= '0;
      sum            <= '0;
      sum_valid      <= 1'b0;
      missed_trigger <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (start_collect && state != S_IDLE)
        missed_trigger <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_collect) begin
            state  <= S_CAPTURE;
            count  <= n_clamped;
            wr_cnt <= '0;
            acc    <= '0;
          end
        end
        S_CAPTURE: begin
          if (cap) begin
            wr_cnt <= wr_cnt + ONE;
            acc    <= acc_next;
            if (last_wr) begin
              sum       <= acc_next;
              sum_valid <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (take && out_last)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read pointer, prefetch slot and output register of the stream
  always_ff @(posedge clk100) begin
    if (reset) begin
      rd_ptr    <= '0;
      pv        <= 1'b0;
      pl        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == S_IDLE && start_collect)
        rd_ptr <= '0;
      else if (rd_en)
        rd_ptr <= rd_ptr + ONE;
      if (rd_en)
        pl <= (rd_ptr == count - ONE);
      pv <= rd_en || (pv && !load);
      if (load) begin
        out_data  <= mem_q;
        out_last  <= pl;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Sample buffer: simple dual port, registered read, no reset
  always_ff @(posedge clk100) begin
    if (cap)
      mem[wr_cnt[ADDR_W-1:0]] <= adc_data;
    if (rd_en)
      mem_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

endmodule

// File: doc/readout_capture.md
# readout_capture

Downstream of the `timing` stage in the qubit readout path. On each `start_collect` pulse it captures a programmed number of ADC samples into an internal buffer and accumulates their signed sum. It then streams the captured samples out over a valid/ready interface, ending with a last-sample marker. The sum, used for averaged readout, is presented as soon as capture ends.

## Interface
- `DATA_W`, default 12: ADC sample width, two's complement.
- `ADDR_W`, default 10: buffer address width; buffer depth is `2**ADDR_W` (1024).
- `clk100`, input, 1: 100 MHz system clock; all logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start_collect`, input, 1: single-cycle capture request from the `timing` stage.
- `num_samples`, input, ADDR_W+1: number of samples to capture; latched on an accepted `start_collect`.
- `adc_data`, input, DATA_W: signed ADC sample.
- `adc_valid`, input, 1: `adc_data` is valid this cycle.
- `out_data`, output, DATA_W: streamed sample.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `out_last`, output, 1: asserted together with `out_valid` on the final sample.
- `sum`, output, DATA_W+ADDR_W+1: signed sum of the captured samples; held until the next capture.
- `sum_valid`, output, 1: one-cycle pulse when `sum` is updated.
- `busy`, output, 1: high in any state other than IDLE.
- `missed_trigger`, output, 1: sticky flag; set when `start_collect` arrives while busy; cleared only by `reset`.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- **IDLE**
  - `start_collect` moves the block to CAPTURE.
  - On that transition: latch `num_samples`, clear the write pointer, clear the accumulator.
  - A latched `num_samples` of 0 or greater than `2**ADDR_W` is clamped to `2**ADDR_W`.
- **CAPTURE**
  - On each `adc_valid`: write `adc_data` to `mem[wr_ptr]`, increment `wr_ptr`, add the sign-extended sample to the accumulator.
  - When the write count reaches the latched count, go to DRAIN.
  - In that same transition, load `sum` and pulse `sum_valid`.
  - `adc_valid` is ignored outside CAPTURE.
- **DRAIN**
  - Read addresses 0 through count-1 in order.
  - The memory read is registered; a prefetch register feeds `out_data` so back-to-back transfers run at one per cycle.
  - A transfer occurs on `out_valid && out_ready`.
  - After the transfer that carries `out_last`, return to IDLE.
- `start_collect` seen in CAPTURE or DRAIN is dropped and sets `missed_trigger`. The current operation is unaffected.
- Accumulator width `DATA_W+ADDR_W+1` cannot overflow: 1024 × (−2048) = −2²¹ fits in 23 bits.
- Memory is a single simple-dual-port array sized for block RAM inference, with no reset on its contents.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `sum`=0, `sum_valid`=0, `busy`=0, `missed_trigger`=0, state=IDLE.
- `start_collect` high in cycle t:
  - `busy` is high from t+1.
  - The first sample captured is the first `adc_valid` in a cycle ≥ t+1.
- The Nth (final) sample is accepted in cycle c.
  - `sum_valid` pulses in c+1.
  - `sum` is valid from c+1 and stable until the next accepted capture.
  - The state is DRAIN in c+1.
  - The first `out_valid` rises no later than c+3.
- Streaming rules:
  - `out_data` and `out_last` hold steady while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
  - With `out_ready` held high, sample throughput is 1 per cycle.
- The final transfer occurs in cycle d.
  - `out_valid`=0 and `busy`=0 in d+1.
  - A new `start_collect` is accepted in d+1.
- `start_collect` coinciding with the final transfer in cycle d is a miss: it sets `missed_trigger`.
- `reset` asserted in any state:
  - The next cycle shows IDLE with all outputs at their reset values.
  - Any partial capture or stream is discarded.

## Test plan
- **Basic capture:** `num_samples`=4, pulse `start_collect`, feed `adc_data` = 10, −3, 7, 100 on consecutive `adc_valid` cycles.
  - `sum_valid` pulses once with `sum`=114.
  - The stream is 10, −3, 7, 100, with `out_last` on 100 only.
- **Gapped valid and backpressure:** `num_samples`=3, `adc_valid` high every third cycle, `out_ready` toggling 1/0.
  - All 3 samples are captured in order.
  - `out_data` holds during every stall.
  - Exactly 3 transfers occur.
- **Full depth, extreme values:** `num_samples`=0 (clamps to 1024), all samples −2048.
  - `sum` = −2097152.
  - 1024 transfers, `out_last` on the 1024th.
- **Missed trigger:** second `start_collect` during CAPTURE.
  - `missed_trigger`=1.
  - The current capture completes with its original count; the flag stays set until `reset`.
- **Reset mid-DRAIN:** assert `reset` after 2 of 8 transfers.
  - Next cycle: `busy`=0, `out_valid`=0.
  - A fresh `start_collect` then captures and streams normally.
- **Back-to-back:** `start_collect` one cycle after the final transfer.
  - Accepted (`busy` high the following cycle).
  - `missed_trigger` stays 0.
